// File: rtl/tx_usr_if.sv
// Transmit-side user interface: repacks 32-bit user words (SOF word carries length)
// into 4-byte TX FIFO words with per-lane eof flags, pads short frames and commits lengths.
module tx_usr_if #(
    parameter int MAX_LEN = 1518,
    parameter int PAD_LEN = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tx_data,
    input  logic        tx_dv,
    input  logic        tx_sof,
    output logic        tx_ack,
    output logic [35:0] txff_din,
    output logic        txff_wr,
    input  logic        txff_full,
    output logic [13:0] tfq_din,
    output logic        tfq_wr,
    input  logic        tfq_full,
    output logic        err
);

    localparam logic [13:0] PAD_L = 14'(PAD_LEN);
    localparam logic [13:0] MAX_L = 14'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DROP} state_t;

    state_t      state_reg, state_next;
    logic [15:0] hold_reg, hold_next;
    logic [12:0] words_left_reg, words_left_next;
    logic [15:0] pos_reg, pos_next;
    logic [13:0] len_reg, len_next;
    logic [13:0] eff_reg, eff_next;
    logic        err_reg, err_next;

    logic [13:0] sof_len;
    logic [13:0] sof_eff;
    logic [14:0] sof_len_m2;
    logic [12:0] sof_nu;

    assign sof_len    = tx_data[29:16];
    assign sof_eff    = (sof_len > PAD_L) ? sof_len : PAD_L;
    assign sof_len_m2 = (sof_len > 14'd2) ? {1'b0, sof_len - 14'd2} : 15'd0;
    assign sof_nu     = 13'((sof_len_m2 + 15'd3) >> 2);

    // Outgoing word is always {upper half, hold}; the upper half only exists in DATA.
    logic [15:0] upper16;
    logic [31:0] word_bytes;
    logic [15:0] eof_idx;
    logic [3:0]  eof_lanes;
    logic        any_eof;

    assign upper16    = (state_reg == DATA) ? tx_data[15:0] : 16'h0000;
    assign word_bytes = {upper16, hold_reg};
    assign eof_idx    = {2'b00, eff_reg} - 16'd1;
    assign any_eof    = |eof_lanes;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] lane_idx;
            logic        lane_valid;
            assign lane_idx   = pos_reg + 16'(gi);
            assign lane_valid = lane_idx < {2'b00, len_reg};
            assign eof_lanes[gi] = (lane_idx == eof_idx);
            assign txff_din[gi*9 +: 9] = {eof_lanes[gi],
                                          lane_valid ? word_bytes[gi*8 +: 8] : 8'h00};
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        words_left_next = words_left_reg;
        pos_next        = pos_reg;
        len_next        = len_reg;
        eff_next        = eff_reg;
        err_next        = 1'b0;
        tx_ack          = 1'b0;
        txff_wr         = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_ack = tx_dv & (~tx_sof | ~tfq_full);
                if (tx_ack) begin
                    if (!tx_sof || sof_len == 14'd0) begin
                        err_next = 1'b1;
                    end else if (sof_len > MAX_L) begin
                        err_next        = 1'b1;
                        words_left_next = sof_nu;
                        if (sof_nu != 13'd0)
                            state_next = DROP;
                    end else begin
                        hold_next       = tx_data[15:0];
                        pos_next        = 16'd0;
                        len_next        = sof_len;
                        eff_next        = sof_eff;
                        words_left_next = sof_nu;
                        state_next      = (sof_nu != 13'd0) ? DATA : TAIL;
                    end
                end
            end
            DATA: begin
                tx_ack = tx_dv & ~txff_full;
                if (tx_ack) begin
                    txff_wr         = 1'b1;
                    hold_next       = tx_data[31:16];
                    pos_next        = pos_reg + 16'd4;
                    words_left_next = words_left_reg - 13'd1;
                    if (words_left_reg == 13'd1)
                        state_next = any_eof ? IDLE : TAIL;
                end
            end
            TAIL: begin
                if (!txff_full) begin
                    txff_wr   = 1'b1;
                    hold_next = 16'h0000;
                    pos_next  = pos_reg + 16'd4;
                    if (any_eof)
                        state_next = IDLE;
                end
            end
            DROP: begin
                tx_ack = tx_dv;
                if (tx_ack) begin
                    words_left_next = words_left_reg - 13'd1;
                    if (words_left_reg == 13'd1)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (reset) begin
            tx_ack  = 1'b0;
            txff_wr = 1'b0;
        end
    end

    // The commit rides on the eof write; tfq space was reserved at SOF acceptance.
    assign tfq_wr  = txff_wr & any_eof;
    assign tfq_din = eff_reg;
    assign err     = err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            hold_reg       <= 16'h0000;
            words_left_reg <= 13'd0;
            pos_reg        <= 16'd0;
            len_reg        <= 14'd0;
            eff_reg        <= 14'd0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            words_left_reg <= words_left_next;
            pos_reg        <= pos_next;
            len_reg        <= len_next;
            eff_reg        <= eff_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: tb/tb_tx_usr_if.sv
// Directed bench for tx_usr_if: one instance with PAD_LEN=60, one with padding disabled.
module tb_tx_usr_if;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tx_data = 32'h0;
    logic        tx_sof = 1'b0;
    logic        dv_a = 1'b0, dv_b = 1'b0;
    logic        full_a = 1'b0, full_b = 1'b0;
    logic        tfq_full_a = 1'b0, tfq_full_b = 1'b0;
    logic        ack_a, ack_b, wr_a, wr_b, tfq_wr_a, tfq_wr_b, err_a, err_b;
    logic [35:0] din_a, din_b;
    logic [13:0] tfq_din_a, tfq_din_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tx_usr_if #(.MAX_LEN(1518), .PAD_LEN(60)) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_dv(dv_a), .tx_sof(tx_sof),
        .tx_ack(ack_a), .txff_din(din_a), .txff_wr(wr_a), .txff_full(full_a),
        .tfq_din(tfq_din_a), .tfq_wr(tfq_wr_a), .tfq_full(tfq_full_a), .err(err_a)
    );

    tx_usr_if #(.MAX_LEN(1518), .PAD_LEN(0)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_dv(dv_b), .tx_sof(tx_sof),
        .tx_ack(ack_b), .txff_din(din_b), .txff_wr(wr_b), .txff_full(full_b),
        .tfq_din(tfq_din_b), .tfq_wr(tfq_wr_b), .tfq_full(tfq_full_b), .err(err_b)
    );

    // Monitor: collects FIFO writes, commits and error pulses per instance.
    logic [35:0] wq_a[$], wq_b[$];
    int tfq_n_a = 0, tfq_n_b = 0, tfq_pos_a = -1, tfq_pos_b = -1;
    int err_n_a = 0, err_n_b = 0, orphan_a = 0, orphan_b = 0;
    logic [13:0] tfq_v_a = 14'h0, tfq_v_b = 14'h0;

    always @(negedge clk) begin
        if (wr_a) wq_a.push_back(din_a);
        if (tfq_wr_a) begin
            tfq_n_a++; tfq_v_a = tfq_din_a; tfq_pos_a = wq_a.size() - 1;
            if (!wr_a) orphan_a++;
        end
        if (err_a) err_n_a++;
        if (wr_b) wq_b.push_back(din_b);
        if (tfq_wr_b) begin
            tfq_n_b++; tfq_v_b = tfq_din_b; tfq_pos_b = wq_b.size() - 1;
            if (!wr_b) orphan_b++;
        end
        if (err_b) err_n_b++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clear_mon();
        wq_a.delete(); wq_b.delete();
        tfq_n_a = 0; tfq_n_b = 0; tfq_pos_a = -1; tfq_pos_b = -1;
        err_n_a = 0; err_n_b = 0; orphan_a = 0; orphan_b = 0;
    endtask

    function automatic logic [7:0] ub(input int i, input int seed);
        return 8'((i + seed) & 255);
    endfunction

    function automatic int nu_of(input int len);
        return (len > 2) ? (len + 1) / 4 : 0;
    endfunction

    // Called at posedge+1; returns at posedge+1 with dv low after the word is accepted.
    task automatic send(input logic [31:0] d, input logic s, input bit b);
        bit got_ack;
        got_ack = 1'b0;
        tx_data = d; tx_sof = s;
        if (b) dv_b = 1'b1; else dv_a = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            got_ack = b ? ack_b : ack_a;
            @(posedge clk); #1;
            if (got_ack) break;
        end
        if (!got_ack) chk("ack_timeout", 64'd0, 64'd1);
        dv_a = 1'b0; dv_b = 1'b0; tx_sof = 1'b0;
    endtask

    task automatic send_frame(input int len, input int seed, input bit b, input int bp_after);
        logic [31:0] w;
        send({2'b00, 14'(len), ub(1, seed), ub(0, seed)}, 1'b1, b);
        for (int k = 0; k < nu_of(len); k++) begin
            w = {ub(4*k+5, seed), ub(4*k+4, seed), ub(4*k+3, seed), ub(4*k+2, seed)};
            if (bp_after != 0 && k == bp_after) begin
                tx_data = w; tx_sof = 1'b0; dv_a = 1'b1; full_a = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("t4_bp_ack", 64'(ack_a), 64'd0);
                    chk("t4_bp_wr", 64'(wr_a), 64'd0);
                    @(posedge clk); #1;
                end
                full_a = 1'b0; dv_a = 1'b0;
            end
            send(w, 1'b0, b);
        end
    endtask

    task automatic check_frame(input string tag, input bit b, input int len, input int eff,
                               input int seed);
        logic [35:0] q[$];
        logic [35:0] exp;
        logic [7:0]  by;
        int nw, i;
        nw = (eff + 3) / 4;
        for (int t = 0; t < 200; t++) begin
            if ((b ? wq_b.size() : wq_a.size()) >= nw) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        if (b) q = wq_b; else q = wq_a;
        chk({tag, "_nwords"}, 64'(q.size()), 64'(nw));
        for (int k = 0; k < nw && k < q.size(); k++) begin
            exp = 36'h0;
            for (int j = 0; j < 4; j++) begin
                i  = 4*k + j;
                by = (i < len) ? ub(i, seed) : 8'h00;
                exp[j*9 +: 9] = {(i == eff - 1), by};
            end
            chk($sformatf("%s_w%0d", tag, k), 64'(q[k]), 64'(exp));
        end
        chk({tag, "_tfq_n"}, 64'(b ? tfq_n_b : tfq_n_a), 64'd1);
        chk({tag, "_tfq_din"}, 64'(b ? tfq_v_b : tfq_v_a), 64'(eff));
        chk({tag, "_tfq_pos"}, 64'(b ? tfq_pos_b : tfq_pos_a), 64'(nw - 1));
        chk({tag, "_orphan"}, 64'(b ? orphan_b : orphan_a), 64'd0);
        chk({tag, "_err"}, 64'(b ? err_n_b : err_n_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with dv held high to prove ack stays low.
        dv_a = 1'b1; dv_b = 1'b1; tx_sof = 1'b1; tx_data = 32'h0040_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack_a", 64'(ack_a), 64'd0);
        chk("rst_ack_b", 64'(ack_b), 64'd0);
        chk("rst_wr", 64'({wr_a, wr_b}), 64'd0);
        chk("rst_tfq_wr", 64'({tfq_wr_a, tfq_wr_b}), 64'd0);
        chk("rst_err", 64'({err_a, err_b}), 64'd0);
        @(posedge clk); #1;
        dv_a = 1'b0; dv_b = 1'b0; tx_sof = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        clear_mon();

        // 1: len 64, no padding needed
        send_frame(64, 0, 1'b0, 0);
        check_frame("t1", 1'b0, 64, 64, 0);
        chk("t1_last_hand", 64'(wq_a[15]), 64'({1'b1, 8'h3F, 1'b0, 8'h3E, 1'b0, 8'h3D, 1'b0, 8'h3C}));
        clear_mon();

        // 2: len 10 padded to 60
        send_frame(10, 128, 1'b0, 0);
        check_frame("t2", 1'b0, 10, 60, 128);
        chk("t2_w2_hand", 64'(wq_a[2]), 64'({1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h89, 1'b0, 8'h88}));
        chk("t2_last_hand", 64'(wq_a[14]), 64'({1'b1, 8'h00, 27'h0}));
        clear_mon();

        // 3: padding disabled, odd tails
        send_frame(66, 0, 1'b1, 0);
        check_frame("t3a", 1'b1, 66, 66, 0);
        chk("t3a_last_hand", 64'(wq_b[16]), 64'({1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h40}));
        clear_mon();
        send_frame(63, 0, 1'b1, 0);
        check_frame("t3b", 1'b1, 63, 63, 0);
        chk("t3b_last_hand", 64'(wq_b[15]), 64'({1'b0, 8'h00, 1'b1, 8'h3E, 1'b0, 8'h3D, 1'b0, 8'h3C}));
        clear_mon();

        // 4: FIFO backpressure after data word 5
        send_frame(64, 0, 1'b0, 5);
        check_frame("t4", 1'b0, 64, 64, 0);
        clear_mon();

        // 5: oversize frame dropped, then a good frame
        send_frame(2000, 7, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_err_n", 64'(err_n_a), 64'd1);
        chk("t5_no_wr", 64'(wq_a.size()), 64'd0);
        chk("t5_no_tfq", 64'(tfq_n_a), 64'd0);
        clear_mon();
        send_frame(64, 5, 1'b0, 0);
        check_frame("t5b", 1'b0, 64, 64, 5);
        clear_mon();

        // 6a: frame queue full holds off SOF
        tx_data = {2'b00, 14'd4, 16'h0100}; tx_sof = 1'b1; dv_a = 1'b1; tfq_full_a = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6a_ack_held", 64'(ack_a), 64'd0);
            @(posedge clk); #1;
        end
        tfq_full_a = 1'b0;
        send_frame(4, 0, 1'b0, 0);
        check_frame("t6a", 1'b0, 4, 60, 0);
        clear_mon();

        // 6b: stray data word in IDLE
        send(32'hDEAD_BEEF, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6b_err_n", 64'(err_n_a), 64'd1);
        chk("t6b_no_wr", 64'(wq_a.size()), 64'd0);
        clear_mon();

        // 6c: reset mid-frame
        send({2'b00, 14'd64, 16'h0100}, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) send(32'h0504_0302 + 32'(k) * 32'h0404_0404, 1'b0, 1'b0);
        tx_data = 32'h1111_1111; dv_a = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("t6c_rst_ack", 64'(ack_a), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; dv_a = 1'b0;
        chk("t6c_no_tfq", 64'(tfq_n_a), 64'd0);
        clear_mon();
        send(32'h2222_2222, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6c_idle_err", 64'(err_n_a), 64'd1);
        chk("t6c_idle_no_wr", 64'(wq_a.size()), 64'd0);
        clear_mon();
        send_frame(64, 9, 1'b0, 0);
        check_frame("t6c", 1'b0, 64, 64, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_usr_if.md
Name: tx_usr_if

Overview:
User-side transmit interface for the MAC. It accepts 32-bit user words and writes them into the TX byte FIFO and the TX frame queue that the MAC transmit engine drains.
- The first user word of a frame carries the 14-bit frame length plus data bytes 0-1.
- The block repacks the stream into 4-byte FIFO words with per-byte end-of-frame flags.
- It zero-pads short frames to PAD_LEN, discards illegal frames, and commits the frame length to the frame queue on the final FIFO write.

Parameters:
MAX_LEN, 1518, largest legal frame length in bytes (1..16383).
PAD_LEN, 60, minimum emitted frame length; 0 disables padding (0..MAX_LEN).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
tx_data  in  32  user word; SOF word = {2'b0, len[13:0], byte1, byte0}; later words = {b3,b2,b1,b0}, lowest address in [7:0]
tx_dv  in  1  tx_data valid
tx_sof  in  1  tx_data is the first word of a frame
tx_ack  out  1  word accepted this cycle (combinational)
txff_din  out  36  {eof3,byte3,eof2,byte2,eof1,byte1,eof0,byte0}; byte0 goes on the wire first
txff_wr  out  1  FIFO write strobe (combinational)
txff_full  in  1  FIFO cannot take a write this cycle
tfq_din  out  14  committed frame length in bytes
tfq_wr  out  1  frame-queue write strobe (combinational)
tfq_full  in  1  frame queue cannot take a write
err  out  1  one-cycle registered pulse on a protocol error

Behaviour:
- Accept condition: a word is accepted when tx_dv & tx_ack. tx_ack is 0 whenever reset is high.
- Reset values:
  - state = IDLE; all counters and the hold register = 0.
  - err = 0; txff_wr = tfq_wr = tx_ack = 0.
  - Reset mid-frame abandons the frame immediately with no tfq write. TXFF/TFQ share this reset, so no orphan bytes survive.
- Derived quantities on the SOF word:
  - len = tx_data[29:16].
  - eff = max(len, PAD_LEN).
  - user words following SOF: nu = ceil(max(len-2,0)/4).
  - FIFO words emitted: ceil(eff/4).
- Byte rules:
  - Emitted byte i = user byte i if i < len, else 8'h00.
  - The eof flag is set only on the lane holding byte eff-1.
  - Lanes after eof carry 8'h00 with eof = 0.
- Repacking: FIFO word k = {user word k+1 [15:0], hold}, where hold = the previous user word's [31:16] (SOF word: its [15:0]).
- States:
  - IDLE
    - tx_ack = tx_dv & (~tx_sof | ~tfq_full).
    - Accepted non-SOF word: discarded, err pulse.
    - Accepted SOF, len = 0: discarded, err pulse, stay IDLE.
    - Accepted SOF, len > MAX_LEN: err pulse, go to DROP with nu words to consume; if nu = 0, stay IDLE.
    - Accepted SOF, otherwise: load hold/counters, no FIFO write; go to DATA if nu > 0, else TAIL.
  - DATA
    - tx_ack = tx_dv & ~txff_full.
    - Each accepted word produces exactly one txff_wr in the same cycle.
    - After the last user word: if bytes remain go to TAIL, else IDLE.
    - tx_sof in DATA is ignored; the word is treated as data.
  - TAIL
    - tx_ack = 0.
    - Each cycle with ~txff_full writes {masked hold, zeros}; the hold is used only on the first TAIL word, later words are all-zero pad.
    - On the eof word, return to IDLE.
  - DROP
    - tx_ack = tx_dv; accepted words are discarded, no writes.
    - When the remaining count reaches 0, go to IDLE.
- Commit: tfq_wr = 1 with tfq_din = eff in exactly the cycle txff_wr carries the eof flag.
  - tfq_full is checked only at SOF acceptance, so the commit is never blocked.
- Backpressure: txff_full high forces txff_wr = 0 and holds state, counters and hold. No data is lost or duplicated.
- Same-cycle SOF acceptance in IDLE directly after the eof write: legal; back-to-back frames have zero gap.

Test Plan:
1. PAD_LEN=60, SOF len=64, 16 data words of incrementing bytes -> 16 txff_wr; last word eof3=1 only, bytes 0..63 in order; tfq_wr with tfq_din=64 on that cycle; err=0.
2. SOF len=10, 2 data words -> 15 txff_wr; bytes 10..59 = 0; eof on word 14 lane 3; tfq_din=60.
3. PAD_LEN=0:
   - SOF len=66, 16 data words -> 17 writes; word 16 = {16'h0, bytes 65,64}, eof1=1; tfq_din=66.
   - Repeat with len=63 -> 16 writes; word 15 byte3 = 0, eof2=1.
4. len=64 frame with txff_full held high for 3 cycles after word 5 -> tx_ack=0 and txff_wr=0 during those 3 cycles; the output byte stream is identical to test 1.
5. SOF len=2000 (MAX_LEN=1518), 500 data words -> err pulse of 1 cycle after SOF; all 500 words acked; no txff_wr/tfq_wr; next SOF len=64 frame passes correctly.
6. Error and reset cases:
   - tfq_full high at SOF -> tx_ack=0 until tfq_full drops.
   - Non-SOF word in IDLE -> acked, err=1 for 1 cycle.
   - reset asserted mid-frame -> next cycle IDLE, no tfq_wr.
